// File: rtl/rope_pkg.sv
// Shared types and defaults for the rope display.
// Contents:
//   rope_state_t   per-rope state: IDLE, MOVING, HELD
//   speed_t        signed speed at the default width
//   x_t            11-bit pixel X coordinate
//   *_COLOR_DEF    RGB332 defaults for moving and held ropes
package rope_pkg;

    localparam int SPEED_W_DEF = 5;

    typedef enum logic [1:0] {IDLE, MOVING, HELD} rope_state_t;
    typedef logic signed [SPEED_W_DEF-1:0] speed_t;
    typedef logic [10:0] x_t;

    localparam logic [7:0] ROPE_COLOR_DEF = 8'hA4;
    localparam logic [7:0] HELD_COLOR_DEF = 8'hE0;

endpackage

// File: rtl/rope_channel.sv
// A single swinging rope. It holds the rope's position, signed speed,
// pending-toggle flag, collision-hold counter, and its registered
// drawing request.
// Ports:
//   clk, rst              clock, async active-high reset
//   sof, enable           frame pulse, run enable
//   pixel_x, pixel_y      current VGA pixel
//   speed_cfg, speed_load shadow speed value and its latch strobe
//   dir_toggle, collision direction-reverse and hold requests
//   x                     left-edge X
//   speed_out             speed while MOVING, 0 otherwise
//   dr, dr_held           registered hit and held status for the pixel
module rope_channel
    import rope_pkg::*;
#(
    parameter int X_INIT      = 100,
    parameter int X_MIN       = 40,
    parameter int X_MAX       = 300,
    parameter int SPEED_W     = 5,
    parameter int HOLD_FRAMES = 30,
    parameter int ROPE_Y_TOP  = 100,
    parameter int ROPE_LEN    = 240,
    parameter int ROPE_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sof,
    input  logic                      enable,
    input  logic [10:0]               pixel_x,
    input  logic [10:0]               pixel_y,
    input  logic signed [SPEED_W-1:0] speed_cfg,
    input  logic                      speed_load,
    input  logic                      dir_toggle,
    input  logic                      collision,
    output x_t                        x,
    output logic signed [SPEED_W-1:0] speed_out,
    output logic                      dr,
    output logic                      dr_held
);
    localparam int CW = $clog2(HOLD_FRAMES + 1);
    localparam logic signed [SPEED_W-1:0] V_MIN = {1'b1, {(SPEED_W-1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] V_SAT = {1'b1, {(SPEED_W-2){1'b0}}, 1'b1};
    localparam logic signed [11:0] LIM_LO = 12'(X_MIN);
    localparam logic signed [11:0] LIM_HI = 12'(X_MAX);
    localparam logic [11:0] Y_LO = 12'(ROPE_Y_TOP);
    localparam logic [11:0] Y_HI = 12'(ROPE_Y_TOP + ROPE_LEN);
    localparam logic [11:0] W12  = 12'(ROPE_W);

    rope_state_t state, state_next;
    logic signed [SPEED_W-1:0] v, v_base, v_next, shadow;
    x_t x_next;
    logic [CW-1:0] hold_cnt, hold_next;
    logic ld_pend, tog_pend, coll_pend;
    logic signed [11:0] sum;
    logic move, bounce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (sof) state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = MOVING;
                MOVING:  if (coll_pend) state_next = HELD;
                HELD:    if (hold_cnt == '0) state_next = MOVING;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb speed_out = (state == MOVING) ? v : '0;

    // A pending load replaces v before the bounce test. Motion happens in
    // any frame whose resulting state is MOVING, including the frame that
    // enters MOVING. A bounce and a pending toggle together negate v once.
    always_comb begin
        v_base = ld_pend ? shadow : v;
        move   = enable && (state_next == MOVING);
        sum    = $signed({1'b0, x}) +
                 $signed({{(12-SPEED_W){v_base[SPEED_W-1]}}, v_base});
        x_next = x;
        bounce = 1'b0;
        if (move) begin
            if (sum > LIM_HI) begin
                x_next = LIM_HI[10:0];
                bounce = 1'b1;
            end else if (sum < LIM_LO) begin
                x_next = LIM_LO[10:0];
                bounce = 1'b1;
            end else begin
                x_next = sum[10:0];
            end
        end
        v_next = (bounce || (enable && tog_pend)) ? -v_base : v_base;
        hold_next = hold_cnt;
        if (state == MOVING && state_next == HELD)
            hold_next = CW'(HOLD_FRAMES - 1);
        else if (state == HELD && state_next == HELD)
            hold_next = hold_cnt - CW'(1);
    end

    // Request strobes come after the frame update, so a request that
    // arrives on the startOfFrame cycle carries into the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= 11'(X_INIT);
            v         <= SPEED_W'(1);
            shadow    <= SPEED_W'(1);
            hold_cnt  <= '0;
            ld_pend   <= 1'b0;
            tog_pend  <= 1'b0;
            coll_pend <= 1'b0;
        end else begin
            if (sof) begin
                x         <= x_next;
                v         <= v_next;
                hold_cnt  <= hold_next;
                ld_pend   <= 1'b0;
                coll_pend <= 1'b0;
                if (enable) tog_pend <= 1'b0;
            end
            if (speed_load) begin
                shadow  <= (speed_cfg == V_MIN) ? V_SAT : speed_cfg;
                ld_pend <= 1'b1;
            end
            if (dir_toggle) tog_pend  <= 1'b1;
            if (collision)  coll_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr      <= 1'b0;
            dr_held <= 1'b0;
        end else begin
            dr <= ({1'b0, pixel_x} >= {1'b0, x}) &&
                  ({1'b0, pixel_x} <  ({1'b0, x} + W12)) &&
                  ({1'b0, pixel_y} >= Y_LO) &&
                  ({1'b0, pixel_y} <  Y_HI);
            dr_held <= (state == HELD);
        end
    end

endmodule

// File: rtl/multi_rope_controller.sv
// Owns ROPES rope channels that are split into a left group and a right
// group. The block merges their drawing requests into one prioritised
// colour and index, and exports positions and effective speeds.
// Ports:
//   clk, reset                 clock, async active-high reset
//   startOfFrame, enable       frame pulse, run enable
//   pixelX, pixelY             current VGA pixel
//   speed_cfg, speed_load      packed per-rope speeds and their latch strobe
//   dirToggle, monkeyCollision per-rope reverse and hold requests
//   ropeDR, anyRopeDR          per-rope and merged drawing requests
//   ropeRGB, hitIndex          colour and index of the lowest-index hit rope
//   ropeX, SIGNED_SPEEDS       packed per-rope X and effective speed
module multi_rope_controller
    import rope_pkg::*;
#(
    parameter int ROPES        = 6,
    parameter int LEFT_ROPES   = 3,
    parameter int LEFT_X0      = 100,
    parameter int RIGHT_X0     = 400,
    parameter int ROPE_SPACING = 40,
    parameter int X_MIN_L      = 40,
    parameter int X_MAX_L      = 300,
    parameter int X_MIN_R      = 340,
    parameter int X_MAX_R      = 600,
    parameter int ROPE_Y_TOP   = 100,
    parameter int ROPE_LEN     = 240,
    parameter int ROPE_W       = 4,
    parameter int SPEED_W      = 5,
    parameter int HOLD_FRAMES  = 30,
    parameter logic [7:0] ROPE_COLOR = ROPE_COLOR_DEF,
    parameter logic [7:0] HELD_COLOR = HELD_COLOR_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic                       enable,
    input  logic [10:0]                pixelX,
    input  logic [10:0]                pixelY,
    input  logic [ROPES*SPEED_W-1:0]   speed_cfg,
    input  logic                       speed_load,
    input  logic [ROPES-1:0]           dirToggle,
    input  logic [ROPES-1:0]           monkeyCollision,
    output logic [ROPES-1:0]           ropeDR,
    output logic                       anyRopeDR,
    output logic [7:0]                 ropeRGB,
    output logic [$clog2(ROPES)-1:0]   hitIndex,
    output logic [ROPES*11-1:0]        ropeX,
    output logic [ROPES*SPEED_W-1:0]   SIGNED_SPEEDS
);
    localparam int IW = $clog2(ROPES);

    logic [ROPES-1:0] held;

    for (genvar i = 0; i < ROPES; i++) begin : g_rope
        localparam bit IS_LEFT = (i < LEFT_ROPES);
        rope_channel #(
            .X_INIT      (IS_LEFT ? LEFT_X0 + i * ROPE_SPACING
                                  : RIGHT_X0 + (i - LEFT_ROPES) * ROPE_SPACING),
            .X_MIN       (IS_LEFT ? X_MIN_L : X_MIN_R),
            .X_MAX       (IS_LEFT ? X_MAX_L : X_MAX_R),
            .SPEED_W     (SPEED_W),
            .HOLD_FRAMES (HOLD_FRAMES),
            .ROPE_Y_TOP  (ROPE_Y_TOP),
            .ROPE_LEN    (ROPE_LEN),
            .ROPE_W      (ROPE_W)
        ) u_channel (
            .clk        (clk),
            .rst        (reset),
            .sof        (startOfFrame),
            .enable     (enable),
            .pixel_x    (pixelX),
            .pixel_y    (pixelY),
            .speed_cfg  (speed_cfg[i*SPEED_W +: SPEED_W]),
            .speed_load (speed_load),
            .dir_toggle (dirToggle[i]),
            .collision  (monkeyCollision[i]),
            .x          (ropeX[i*11 +: 11]),
            .speed_out  (SIGNED_SPEEDS[i*SPEED_W +: SPEED_W]),
            .dr         (ropeDR[i]),
            .dr_held    (held[i])
        );
    end

    assign anyRopeDR = |ropeDR;

    // Scan from the highest index down so the lowest hit index wins.
    always_comb begin
        hitIndex = '0;
        ropeRGB  = '0;
        for (int unsigned k = 0; k < ROPES; k++) begin
            if (ropeDR[ROPES-1-k]) begin
                hitIndex = IW'(ROPES - 1 - k);
                ropeRGB  = held[ROPES-1-k] ? HELD_COLOR : ROPE_COLOR;
            end
        end
    end

endmodule

// File: doc/multi_rope_controller.md
Name: multi_rope_controller

Overview:
- Parametrised successor to the per-level rope display. Owns ROPES swinging ropes, split into a left group and a right group.
- Each rope has its own frame-stepped X position, signed speed, bounce limits, and collision-hold state machine.
- Merges all rope drawing requests into one prioritised DR/RGB/index for the VGA mux.
- Feeds signed speeds and positions to the monkey physics block.

Parameters:
ROPES, 6, total rope channels
LEFT_ROPES, 3, channels 0..LEFT_ROPES-1 are left group; rest are right group
LEFT_X0, 100, initial X of rope 0 (pixels)
RIGHT_X0, 400, initial X of first right rope
ROPE_SPACING, 40, X spacing between consecutive ropes of a group at reset
X_MIN_L / X_MAX_L, 40 / 300, left group bounce limits (left edge of rope)
X_MIN_R / X_MAX_R, 340 / 600, right group bounce limits
ROPE_Y_TOP, 100, top row of every rope
ROPE_LEN, 240, rope height in pixels
ROPE_W, 4, rope width in pixels
SPEED_W, 5, signed speed width (pixels/frame)
HOLD_FRAMES, 30, frames a rope freezes after monkey collision
ROPE_COLOR / HELD_COLOR, 8'hA4 / 8'hE0, RGB332 colours for moving / held rope

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
enable  in  1  level; ropes leave IDLE when high
pixelX, pixelY  in  11 each  current VGA pixel
speed_cfg  in  ROPES x SPEED_W  signed speed per rope
speed_load  in  1  pulse; latch speed_cfg
dirToggle  in  ROPES  pulse per rope; reverse direction
monkeyCollision  in  ROPES  pulse/level per rope; start hold
ropeDR  out  ROPES  per-rope drawing request
anyRopeDR  out  1  OR of ropeDR
ropeRGB  out  8  colour of highest-priority hit rope
hitIndex  out  $clog2(ROPES)  lowest-index rope hit at this pixel
ropeX  out  ROPES x 11  current left-edge X per rope
SIGNED_SPEEDS  out  ROPES x SPEED_W  effective signed speed (0 when not MOVING)

Behaviour:
- Reset (async, active-high):
  - Rope i in the left group: X = LEFT_X0 + i*ROPE_SPACING. Rope i in the right group: X = RIGHT_X0 + (i-LEFT_ROPES)*ROPE_SPACING.
  - Latched speed = +1 for all ropes. All FSMs go to IDLE.
  - Pending-toggle flags cleared; hold counters cleared.
  - All outputs 0, except ropeX, which shows the reset positions.
- Per-channel FSM; state changes only at startOfFrame unless noted:
  - IDLE -> MOVING at startOfFrame when enable = 1.
  - MOVING -> HELD when monkeyCollision was seen since the previous frame. The hold counter loads HOLD_FRAMES-1.
  - HELD: counter decrements at each startOfFrame; at 0 -> MOVING. Collisions during HELD are ignored; the counter is not restarted.
  - Any state -> IDLE at startOfFrame when enable = 0. Position and speed are kept.
- Motion, MOVING, at startOfFrame:
  - next = X + v, computed as signed 12-bit.
  - next > XMAX: X = XMAX and v = -v. next < XMIN: X = XMIN and v = -v. Otherwise X = next.
  - v = 0 is legal; the rope stays still.
- dirToggle:
  - A pulse at any cycle sets the pending flag. At the next startOfFrame, in MOVING or HELD, v = -v and the flag clears.
  - In IDLE the flag is held until MOVING.
  - Bounce and pending toggle in the same frame: exactly one negation; the flag clears.
- speed_load:
  - Latches speed_cfg into shadow registers at once; they are applied at the next startOfFrame.
  - If applied in the same frame as a bounce or toggle, the loaded value is used, then the bounce is evaluated with the new v.
  - Loading the most-negative value saturates to -(2^(SPEED_W-1)-1).
- SIGNED_SPEEDS: latched v in MOVING; 0 in IDLE/HELD. Registered; updates the cycle after startOfFrame.
- Drawing, one registered stage (1 clk latency from pixelX/pixelY):
  - ropeDR[i] = (X_i <= pixelX < X_i+ROPE_W) and (ROPE_Y_TOP <= pixelY < ROPE_Y_TOP+ROPE_LEN).
  - anyRopeDR = OR of ropeDR. hitIndex = lowest asserted index, 0 when none.
  - ropeRGB = HELD_COLOR if that rope is HELD, else ROPE_COLOR; 0 when none.
- Reset mid-frame: takes effect immediately; the drawing stage is cleared the same cycle.

Decomposition:
- Package rope_pkg: rope_state_t enum {IDLE, MOVING, HELD}, speed_t signed [SPEED_W-1:0], x_t [10:0], default colour constants.
- Sub-module rope_channel: FSM, position, speed, pending-toggle and hold counter for one rope, plus its ropeDR compare.
- Top instantiates ROPES channels via generate. Each channel gets its group limits and initial X from the index, and the top does the priority merge.

Test Plan:
- Reset, enable = 1, one startOfFrame, default speeds -> rope0 X 100->101, rope3 X 400->401; SIGNED_SPEEDS[0] = +1.
- Rope0 speed_load +7 at X = 296, one frame -> X = 300 (XMAX_L), v = -7; next frame X = 293.
- dirToggle[1] pulse and bounce in the same frame -> single reversal; a second frame confirms the direction.
- monkeyCollision[2] pulse -> SIGNED_SPEEDS[2] = 0 and X frozen for 30 frames; colour is HELD_COLOR on rope pixels; motion resumes on frame 31; a collision at frame 10 does not extend the hold.
- Pixel (102,150) with ropes 0 and 1 overlapping at X = 100 and 101 -> one clk later ropeDR = 6'b000011, hitIndex = 0, anyRopeDR = 1; pixel (102,99) -> all 0.
- reset asserted while HELD mid-frame -> all channels IDLE, X at reset positions, outputs 0 in the same cycle.
